rx_word_aligner: RTL

RX_WORD_ALIGNER -- requirements
Module: rx_word_aligner

---
 rtl/rx_word_aligner.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rx_word_aligner.sv
// rx_word_aligner: per-lane bit-slip word aligner for a deserializer.
// Each lane builds a 2*WIDTH window from its current and previous words.
// While a training pattern is sent, the lane slides a bit offset across
// that window until it has seen LOCK_COUNT consecutive matches. It then
// locks and freezes the offset.
//
// Optional feature macro: RX_ALIGN_ERRCNT_EN. When it is defined, the block
// adds a 16-bit saturating count, per lane, of mismatches seen while locked.
//
// Ports:
//   clk          word clock (slowest divided deserializer clock)
//   rst          asynchronous active-high reset
//   din          LANES*WIDTH deserializer words, lane n at [n*WIDTH +: WIDTH]
//   din_valid    qualifies din on all lanes
//   train_en     training pattern in flight; enables slip search
//   pattern      expected training word
//   realign      single-cycle pulse that restarts alignment on all lanes
//   dout         LANES*WIDTH aligned words (1 clk latency)
//   dout_valid   qualifies dout
//   slip_offset  LANES*OFF_W current bit offset per lane
//   lane_locked  per-lane lock flag
//   all_locked   AND of lane_locked
//   err_cnt      LANES*16 locked-mismatch counts (RX_ALIGN_ERRCNT_EN only)

`ifndef SERDES_STAGES
`define SERDES_STAGES 3
`endif

module rx_word_aligner #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned WIDTH      = 2**`SERDES_STAGES,
  parameter int unsigned LOCK_COUNT = 4,
  localparam int unsigned OFF_W     = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*WIDTH-1:0] din,
  input  logic                   din_valid,
  input  logic                   train_en,
  input  logic [WIDTH-1:0]       pattern,
  input  logic                   realign,
  output logic [LANES*WIDTH-1:0] dout,
  output logic                   dout_valid,
  output logic [LANES*OFF_W-1:0] slip_offset,
  output logic [LANES-1:0]       lane_locked,
  output logic                   all_locked
`ifdef RX_ALIGN_ERRCNT_EN
  ,
  output logic [LANES*16-1:0]    err_cnt
`endif
);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_valid <= 1'b0;
    else     dout_valid <= din_valid;
  end

  assign all_locked = &lane_locked;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [WIDTH-1:0]   word;
    logic [WIDTH-1:0]   prev;
    logic [2*WIDTH-1:0] window;
    logic [WIDTH-1:0]   aligned;
    logic [WIDTH-1:0]   dout_q;
    logic               match;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [3:0]         cnt_q, cnt_d;
    state_t             state_q, state_d;

    assign word    = din[n*WIDTH +: WIDTH];
    assign window  = {word, prev};
    assign aligned = window[off_q +: WIDTH];
    assign match   = (aligned == pattern);

    assign dout[n*WIDTH +: WIDTH]        = dout_q;
    assign slip_offset[n*OFF_W +: OFF_W] = off_q;
    assign lane_locked[n]                = (state_q == LOCKED);

    // Data path keeps running through realign; only alignment state restarts.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev   <= '0;
        dout_q <= '0;
      end else if (din_valid) begin
        prev   <= word;
        dout_q <= aligned;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= SEARCH;
        off_q   <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        off_q   <= off_d;
        cnt_q   <= cnt_d;
      end
    end

    // WIDTH is a power of two, so the OFF_W-bit increment wraps WIDTH-1 -> 0.
    always_comb begin
      state_d = state_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      if (realign) begin
        state_d = SEARCH;
        off_d   = '0;
        cnt_d   = '0;
      end else if (din_valid && train_en) begin
        unique case (state_q)
          SEARCH: begin
            if (match) begin
              cnt_d   = 4'd1;
              state_d = (LOCK_COUNT == 1) ? LOCKED : CONFIRM;
            end else begin
              off_d = off_q + OFF_W'(1);
            end
          end
          CONFIRM: begin
            if (match) begin
              cnt_d = cnt_q + 4'd1;
              if (cnt_q + 4'd1 == 4'(LOCK_COUNT)) state_d = LOCKED;
            end else begin
              state_d = SEARCH;
              cnt_d   = '0;
              off_d   = off_q + OFF_W'(1);
            end
          end
          LOCKED: begin
          end
          default: state_d = SEARCH;
        endcase
      end
    end

`ifdef RX_ALIGN_ERRCNT_EN
    logic [15:0] err_q;

    assign err_cnt[n*16 +: 16] = err_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        err_q <= '0;
      end else if (realign) begin
        err_q <= '0;
      end else if (din_valid && train_en && state_q == LOCKED && !match
                   && err_q != '1) begin
        err_q <= err_q + 16'd1;
      end
    end
`endif
  end

endmodule
